fsm_in: RTL and testbench
=========================

# fsm_in

Byte-stream receiver and word packer for the 8-bit strobed link. It collects eight consecutive bytes framed by `strobe_in`/`data_end_in` into one 64-bit word and writes it into the RX FIFO with a single-cycle write pulse. Malformed frames are discarded and flagged. FIFO-full drops are flagged separately. It sits between the link pins/synchroniser and the 64-bit RX FIFO.

## Interface
- `CNT_W`, default 16: width of the saturating good-frame and error counters.
- `clk`  in  1: single clock for the whole block.
- `reset_n`  in  1: asynchronous, active-low reset.
- `strobe_in`  in  1: byte valid; high for every byte of a frame, contiguously.
- `data_in`  in  8: byte payload, valid when `strobe_in`=1.
- `data_end_in`  in  1: marks the last (8th) byte; meaningful only with `strobe_in`=1.
- `fifo_full`  in  1: RX FIFO cannot accept a write.
- `write_enable`  out  1: one-cycle FIFO write pulse.
- `fifo_wdata`  out  64: assembled word, valid while `write_enable`=1.
- `busy`  out  1: a frame is in progress (state COLLECT or DISCARD).
- `frame_err`  out  1: one-cycle pulse when a frame is discarded as malformed.
- `overflow`  out  1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- `good_cnt`  out  CNT_W: count of words written; saturates at all-ones.
- `err_cnt`  out  CNT_W: count of `frame_err` plus `overflow` events; saturates at all-ones.

## Operation
- Byte order is little-endian: byte k of a frame goes to `fifo_wdata[8k+7:8k]`. The first byte is byte 0, placed in bits [7:0].
- Byte index counter runs 0..7. An accepted byte is any cycle with `strobe_in`=1 in IDLE or COLLECT.
- States:
  - **IDLE**
    - `strobe_in`=1: store byte 0, index←1, go to COLLECT.
    - `strobe_in`=1 with `data_end_in`=1: one-byte frame; error, stay in IDLE.
  - **COLLECT**
    - `strobe_in`=1, index<7, `data_end_in`=0: store the byte, index+1.
    - `strobe_in`=1, index<7, `data_end_in`=1: short frame; error, go to IDLE.
    - `strobe_in`=0, any index: gap in frame; error, go to IDLE.
    - `strobe_in`=1, index=7, `data_end_in`=1: frame complete.
      - `fifo_full`=0 in that cycle: write the word.
      - `fifo_full`=1 in that cycle: overflow; the word is dropped.
      - Go to IDLE in both cases.
    - `strobe_in`=1, index=7, `data_end_in`=0: long frame; error, go to DISCARD.
  - **DISCARD**: ignore bytes until a cycle with `strobe_in`=0, then go to IDLE. That `strobe_in`=0 cycle is not a byte.
- `data_end_in` without `strobe_in` is ignored in every state.
- An error pulses `frame_err` for one cycle, increments `err_cnt`, and writes nothing. Partial data is discarded.
- Reset, asserted at any time including mid-frame:
  - State→IDLE, index→0.
  - All outputs→0: `write_enable`=0, `fifo_wdata`=0, `busy`=0, `frame_err`=0, `overflow`=0, `good_cnt`=0, `err_cnt`=0.
  - The in-flight frame is lost and no pulse is generated.
- Counters: +1 per event and hold at 2^CNT_W−1. The two counters never increment more than once per cycle.

## Timing
- All outputs are registered.
- Latency: the 8th byte is accepted at edge N. `write_enable`=1 and `fifo_wdata` are valid for cycle N+1 only. `good_cnt` updates at the same edge.
- `frame_err` and `overflow` are asserted the cycle after the offending input cycle, for exactly one cycle.
- Back-to-back frames need zero gap. Byte 0 of the next frame may arrive the cycle immediately after the previous `data_end_in`. The assembly register is separate from the `fifo_wdata` register, so this causes no corruption.
- `fifo_wdata` holds its last written value when `write_enable`=0.
- `busy` is high from the cycle after byte 0 until the cycle after the frame ends or is aborted.
- `fifo_full` is sampled only in the completion cycle. No retry or backpressure is applied toward the link.

## Structure
- Shared package `fsm_link_pkg`:
  - `BYTES_PER_WORD`=8
  - `WORD_W`=64
  - `BYTE_W`=8
  - state enum `rx_state_t` {IDLE, COLLECT, DISCARD}
- The TX side uses the same byte-order and framing constants from this package.
- One sub-module, `sat_counter` (parameter `W`; ports clk, reset_n, inc, count), instantiated twice.

## Test plan
- Bytes 0x11..0x88 on consecutive cycles, `data_end_in` with 0x88, `fifo_full`=0 → one `write_enable` pulse with `fifo_wdata`=0x8877665544332211, `good_cnt`=1.
- Two frames back-to-back with zero gap (0x01..0x08, then 0xA1..0xA8) → writes 0x0807060504030201 then 0xA8A7A6A5A4A3A2A1 on separate cycles, `good_cnt`=2.
- `strobe_in` drops after 5 bytes → `frame_err` pulse, no write, `err_cnt`=1. The next valid frame is written correctly.
- 10 bytes with no `data_end_in` → `frame_err` after the 8th byte, bytes 9–10 ignored, no write, back to IDLE after `strobe_in` goes low.
- Valid frame with `fifo_full`=1 in the completion cycle → `overflow` pulse, no `write_enable`, `err_cnt`+1, `good_cnt` unchanged.
- `reset_n` asserted after byte 4, then a full frame 0xF0..0xF7 → no pulses during reset, all outputs 0. The write is `fifo_wdata`=0xF7F6F5F4F3F2F1F0.

Source files
------------

// File: rtl/fsm_link_pkg.sv
// ---------------------------------------------------------------------------
// fsm_link_pkg
// Shared constants and types for the 8-bit strobed link. The RX packer and
// the TX side both use these, so they agree on framing and byte order.
//   BYTES_PER_WORD : bytes per frame / per FIFO word
//   WORD_W         : FIFO word width
//   BYTE_W         : link byte width
//   IDX_W          : width of the byte index counter
//   rx_state_t     : receiver FSM state
// ---------------------------------------------------------------------------
package fsm_link_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int WORD_W         = 64;
    localparam int BYTE_W         = 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } rx_state_t;

    // True when the index points at the final byte slot of a word.
    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one per cycle with inc=1 and holds at
// all-ones instead of wrapping.
//   clk     : clock
//   reset_n : asynchronous active-low reset, clears count
//   inc     : count one event this cycle
//   count   : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fsm_in.sv
// ---------------------------------------------------------------------------
// fsm_in
// Receives 8-byte frames from the strobed link, packs them little-endian into
// a 64-bit word and writes the word to the RX FIFO with a one-cycle pulse.
// Malformed frames (one-byte, short, gapped, long) are discarded and flagged
// on frame_err; good frames hitting a full FIFO are dropped and flagged on
// overflow.
//
// Handshake: strobe_in qualifies data_in/data_end_in each cycle; there is no
// backpressure toward the link. write_enable is a one-cycle write strobe with
// fifo_wdata valid in the same cycle; fifo_full is sampled only in the cycle
// the 8th byte arrives and a full FIFO drops the word.
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   strobe_in          : byte valid
//   data_in[7:0]       : byte payload
//   data_end_in        : last byte of frame (qualified by strobe_in)
//   fifo_full          : RX FIFO cannot accept a write
//   write_enable       : FIFO write pulse
//   fifo_wdata[63:0]   : assembled word, held between writes
//   busy               : frame in progress (COLLECT or DISCARD)
//   frame_err          : pulse, malformed frame discarded
//   overflow           : pulse, good frame dropped on full FIFO
//   good_cnt, err_cnt  : saturating event counters
//   state_dbg          : current FSM state for observation
// ---------------------------------------------------------------------------
module fsm_in
    import fsm_link_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              strobe_in,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_end_in,
    input  logic              fifo_full,
    output logic              write_enable,
    output logic [WORD_W-1:0] fifo_wdata,
    output logic              busy,
    output logic              frame_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output rx_state_t         state_dbg
);

    rx_state_t         state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q, ferr_q, ovf_q, busy_q;

    // Next-cycle pulse values. The counters consume these directly so they
    // update on the same edge as the registered pulses.
    logic we_d, ferr_d, ovf_d;
    logic last_idx;

    assign last_idx = is_last_idx(idx_q);

    always_comb begin
        we_d   = 1'b0;
        ferr_d = 1'b0;
        ovf_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A frame that ends on its first byte is malformed.
                if (strobe_in && data_end_in) ferr_d = 1'b1;
            end
            COLLECT: begin
                if (!strobe_in) begin
                    ferr_d = 1'b1;
                end else if (!last_idx) begin
                    ferr_d = data_end_in;
                end else if (data_end_in) begin
                    we_d  = !fifo_full;
                    ovf_d = fifo_full;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
            // The completing byte goes straight into the output word, so the
            // assembly register is free for the next frame's byte 0.
            if (we_d) begin
                wdata_q <= {data_in, asm_q[WORD_W-BYTE_W-1:0]};
            end
            case (state_q)
                IDLE: begin
                    if (strobe_in && !data_end_in) begin
                        asm_q[BYTE_W-1:0] <= data_in;
                        idx_q             <= IDX_W'(1);
                        state_q           <= COLLECT;
                        busy_q            <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (!strobe_in || (!last_idx && data_end_in)) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!last_idx) begin
                        asm_q[idx_q*BYTE_W +: BYTE_W] <= data_in;
                        idx_q                         <= idx_q + IDX_W'(1);
                    end else begin
                        idx_q <= '0;
                        if (data_end_in) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Long frame: swallow the rest until strobe drops.
                            state_q <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (!strobe_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (we_d),
        .count   (good_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (ferr_d | ovf_d),
        .count   (err_cnt)
    );

    assign write_enable = we_q;
    assign fifo_wdata   = wdata_q;
    assign busy         = busy_q;
    assign frame_err    = ferr_q;
    assign overflow     = ovf_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_fsm_in.sv
module tb_fsm_in;
  import fsm_link_pkg::*;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        strobe_in, data_end_in, fifo_full;
  logic [7:0]  data_in;
  logic        write_enable, busy, frame_err, overflow;
  logic [63:0] fifo_wdata;
  logic [CNT_W-1:0] good_cnt, err_cnt;
  rx_state_t   state_dbg;

  fsm_in #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .strobe_in    (strobe_in),
    .data_in      (data_in),
    .data_end_in  (data_end_in),
    .fifo_full    (fifo_full),
    .write_enable (write_enable),
    .fifo_wdata   (fifo_wdata),
    .busy         (busy),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .good_cnt     (good_cnt),
    .err_cnt      (err_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        strobe;
    logic [7:0]  data;
    logic        dend;
    logic        full;
    logic        exp_we;
    logic        exp_ferr;
    logic        exp_ovf;
    logic        exp_busy;
    logic [63:0] word;
  } vec_t;

  vec_t        vec_q[$];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [CNT_W-1:0] exp_good, exp_err;
  logic [63:0] exp_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] d, input logic e, input logic f,
                              input logic we, input logic fe, input logic ov, input logic b,
                              input logic [63:0] w);
    vec_t v;
    v.strobe = s; v.data = d; v.dend = e; v.full = f;
    v.exp_we = we; v.exp_ferr = fe; v.exp_ovf = ov; v.exp_busy = b; v.word = w;
    return v;
  endfunction

  task automatic add_vec(input vec_t v);
    vec_q.push_back(v);
  endtask

  task automatic add_idle();
    add_vec(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
  endtask

  // Eight-byte frame of word w; full_mask[k] drives fifo_full on byte k.
  task automatic add_frame(input logic [63:0] w, input logic [7:0] full_mask);
    for (int k = 0; k < 8; k++) begin
      logic last;
      last = (k == 7);
      add_vec(mk(1'b1, w[8*k +: 8], last, full_mask[k], last && !full_mask[k], 1'b0,
                 last && full_mask[k], !last, w));
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Drive one vector, then compare outputs after the capturing edge.
  task automatic apply(input vec_t v, input int step);
    strobe_in   = v.strobe;
    data_in     = v.data;
    data_end_in = v.dend;
    fifo_full   = v.full;
    if (v.exp_we) exp_q.push_back(v.word);
    @(negedge clk);
    if (v.exp_we) begin
      exp_good = sat_inc(exp_good);
      exp_last = v.word;
    end
    if (v.exp_ferr || v.exp_ovf) exp_err = sat_inc(exp_err);
    check($sformatf("we[%0d]", step),    64'(write_enable), 64'(v.exp_we));
    check($sformatf("ferr[%0d]", step),  64'(frame_err),    64'(v.exp_ferr));
    check($sformatf("ovf[%0d]", step),   64'(overflow),     64'(v.exp_ovf));
    check($sformatf("busy[%0d]", step),  64'(busy),         64'(v.exp_busy));
    check($sformatf("good[%0d]", step),  64'(good_cnt),     64'(exp_good));
    check($sformatf("err[%0d]", step),   64'(err_cnt),      64'(exp_err));
    check($sformatf("wdata[%0d]", step), fifo_wdata,        exp_last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(write_enable), 64'h0);
    check({tag, "_wdata"}, fifo_wdata,        64'h0);
    check({tag, "_busy"},  64'(busy),         64'h0);
    check({tag, "_ferr"},  64'(frame_err),    64'h0);
    check({tag, "_ovf"},   64'(overflow),     64'h0);
    check({tag, "_good"},  64'(good_cnt),     64'h0);
    check({tag, "_err"},   64'(err_cnt),      64'h0);
  endtask

  // Word scoreboard: every FIFO write must match the next expected word.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && write_enable === 1'b1) begin
      logic [63:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL word_sb: unexpected write %h", fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        if (fifo_wdata === e) n_pass++;
        else $display("FAIL word_sb: got %h expected %h", fifo_wdata, e);
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    logic [63:0] rw;
    reset_n = 1'b0; strobe_in = 1'b0; data_in = 8'h00; data_end_in = 1'b0; fifo_full = 1'b0;
    exp_good = '0; exp_err = '0; exp_last = '0;

    // Table fill.
    // Basic frame.
    add_frame(64'h8877665544332211, 8'h00); add_idle();
    // Back-to-back frames with zero gap.
    add_frame(64'h0807060504030201, 8'h00);
    add_frame(64'hA8A7A6A5A4A3A2A1, 8'h00); add_idle();
    // Strobe gap after five bytes, then a good frame.
    for (int k = 0; k < 5; k++) add_vec(mk(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0));
    add_vec(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0));
    add_idle();
    add_frame(64'h3F3E3D3C3B3A3938, 8'h00); add_idle();
    // Ten bytes, no end on byte 8; end on byte 10 is ignored in DISCARD.
    for (int k = 0; k < 10; k++)
      add_vec(mk(1'b1, 8'(8'h40 + k), k == 9, 1'b0, 1'b0, k == 7, 1'b0, 1'b1, 64'h0));
    add_vec(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
    add_idle();
    // FIFO full at completion, then full only on non-completion bytes.
    add_frame(64'hC7C6C5C4C3C2C1C0, 8'h80); add_idle();
    add_frame(64'hD7D6D5D4D3D2D1D0, 8'h7F); add_idle();
    // One-byte frame, data_end without strobe, three-byte short frame.
    add_vec(mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0));
    add_vec(mk(1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
    add_vec(mk(1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0));
    add_vec(mk(1'b1, 8'h72, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0));
    add_vec(mk(1'b1, 8'h73, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0));
    add_idle();
    // Random back-to-back frames push good_cnt into saturation.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) rw[8*k +: 8] = 8'($urandom_range(0, 255));
      add_frame(rw, 8'h00);
    end
    add_idle();
    // One-byte errors push err_cnt into saturation.
    for (int f = 0; f < 4; f++) begin
      add_vec(mk(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0));
      add_idle();
    end

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    foreach (vec_q[i]) apply(vec_q[i], i);

    // Reset asserted mid-frame after four bytes.
    for (int k = 0; k < 4; k++)
      apply(mk(1'b1, 8'(8'hE0 + k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0), 1000 + k);
    strobe_in = 1'b1; data_in = 8'hE4;
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    check_all_zero("rst_hold");
    exp_good = '0; exp_err = '0; exp_last = '0;
    strobe_in = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++)
      apply(mk(1'b1, 8'(8'hF0 + k), k == 7, 1'b0, k == 7, 1'b0, 1'b0, k != 7,
               64'hF7F6F5F4F3F2F1F0), 2000 + k);
    apply(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0), 2008);

    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
